bp_fe_ltb_ctrl: RTL
===================

// Module: bp_fe_ltb_ctrl
// PURPOSE
//  Sequencing and arbitration controller for the front-end loop termination buffer (LTB).
//  The LTB storage is a single-ported synchronous RAM; this block shares it between the
//  prediction read port and the branch-resolution update (write) port.
//  After reset it runs an init sweep that zeroes every entry.
//  It buffers one pending update and forwards buffered update data to colliding reads.
// PARAMETERS
//  vaddr_width_p      39  virtual address width of read/update PCs
//  ltb_idx_width_p    6   log2(LTB entries); index = addr[ltb_idx_width_p+1:2]
//  ltb_entry_width_p  40  packed entry width (tag, conf, spec/non-spec/trip counts)
//  max_stall_p        4   max consecutive cycles a buffered write may lose to reads; must be >=1
// PORTS
//  clk_i          in   1        clock; all state updates on posedge
//  reset_n_i      in   1        synchronous reset, active-low
//  r_v_i          in   1        prediction read request
//  r_addr_i       in   vaddr    read PC
//  r_ready_o      out  1        read accepted when r_v_i & r_ready_o
//  w_v_i          in   1        update request
//  w_addr_i       in   vaddr    update PC
//  w_data_i       in   entry    update entry
//  w_yumi_o       out  1        update consumed this cycle (valid-then-yumi)
//  ram_v_o        out  1        RAM access enable
//  ram_w_o        out  1        1 = write, 0 = read
//  ram_addr_o     out  idx      RAM index
//  ram_data_o     out  entry    RAM write data
//  ram_data_i     in   entry    RAM read data, valid 1 cycle after a read
//  pred_v_o       out  1        prediction response valid (registered)
//  pred_data_o    out  entry    prediction entry
//  init_done_o    out  1        init sweep complete
// BEHAVIOUR
//  Reset (reset_n_i==0 at posedge):
//   - state<=e_clear, clr_ptr<=0, wb_v<=0, stall_cnt<=0, pred_v_o<=0.
//   - While in reset: all outputs are 0.
//  Reset mid-operation:
//   - The buffered write is dropped.
//   - An in-flight read produces no response.
//   - The sweep restarts at index 0.
//  e_clear (reset_n_i==1):
//   - Every cycle drives ram_v_o=1, ram_w_o=1, ram_addr_o=clr_ptr, ram_data_o=0; clr_ptr++.
//   - When clr_ptr==2^idx-1 the next state is e_run. The sweep takes exactly 2^idx cycles.
//   - r_ready_o=0 and w_yumi_o=0 throughout.
//  e_run (terminal until reset):
//   - init_done_o=1.
//   - force_w = wb_v & (stall_cnt==max_stall_p); r_ready_o = ~force_w.
//   - RAM grant priority:
//     1. force_w: write the buffer.
//     2. r_v_i: read at r_addr_i index.
//     3. wb_v: write the buffer.
//     4. Otherwise ram_v_o=0.
//   - On a buffer write: ram_addr_o=wb_idx, ram_data_o=wb_data.
//  Write buffer (1 entry):
//   - w_yumi_o = e_run & w_v_i & (~wb_v | wb drains this cycle).
//   - On w_yumi_o the buffer loads {w_addr_i idx, w_data_i}.
//   - Drain and refill in the same cycle leaves wb_v=1 holding the new data.
//  stall_cnt:
//   - +1 when wb_v and a read wins the RAM; saturates at max_stall_p.
//   - Cleared to 0 when the buffer drains.
//  Response:
//   - pred_v_o is registered: 1 exactly 1 cycle after an accepted read.
//   - pred_data_o = fwd_r ? fwd_data_r : ram_data_i.
//   - fwd_r is set when the read is accepted while wb_v & wb_idx==read idx; the buffered
//     data is captured at that time.
//  A write accepted via w_yumi_o in the same cycle as a same-index read is NOT forwarded;
//  the read observes pre-write state.
// TESTING
//  1. Release reset with idx=6: 64 consecutive zero writes to addr 0..63, then init_done_o=1
//     on cycle 65; r_ready_o=0 and w_yumi_o=0 throughout.
//  2. Write idx 5 data 0xAB with no reads: w_yumi_o same cycle, RAM write next cycle.
//     Read idx 5 later: pred_v_o 1 cycle later, pred_data_o=0xAB.
//  3. Continuous r_v_i with 1 buffered write, max_stall_p=4: 4 reads granted, then r_ready_o=0
//     for 1 cycle while the write drains; stall_cnt returns to 0.
//  4. Buffered write idx 9=0x5A, read idx 9 the same cycle: the read wins RAM, and the
//     response is 0x5A via forwarding, not the RAM data.
//  5. Drain and new write in the same cycle: w_yumi_o=1, the buffer holds the new data, and
//     both writes reach RAM in order.
//  6. Assert reset_n_i=0 mid-run with a write buffered and a read in flight: no pred_v_o,
//     the buffered write is never issued, and the sweep restarts at 0.

Source files
------------

// File: rtl/bp_fe_ltb_ctrl.sv
// Loop termination buffer controller: shares a single-ported LTB RAM between prediction
// reads and buffered branch-resolution writes, with a post-reset zeroing sweep.
module bp_fe_ltb_ctrl #(
    parameter int vaddr_width_p     = 39,
    parameter int ltb_idx_width_p   = 6,
    parameter int ltb_entry_width_p = 40,
    parameter int max_stall_p       = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic                         r_v_i,
    input  logic [vaddr_width_p-1:0]     r_addr_i,
    output logic                         r_ready_o,

    input  logic                         w_v_i,
    input  logic [vaddr_width_p-1:0]     w_addr_i,
    input  logic [ltb_entry_width_p-1:0] w_data_i,
    output logic                         w_yumi_o,

    output logic                         ram_v_o,
    output logic                         ram_w_o,
    output logic [ltb_idx_width_p-1:0]   ram_addr_o,
    output logic [ltb_entry_width_p-1:0] ram_data_o,
    input  logic [ltb_entry_width_p-1:0] ram_data_i,

    output logic                         pred_v_o,
    output logic [ltb_entry_width_p-1:0] pred_data_o,
    output logic                         init_done_o
);

    localparam int stall_width_lp = $clog2(max_stall_p + 1);
    localparam logic [stall_width_lp-1:0]  stall_max_lp = stall_width_lp'(max_stall_p);
    localparam logic [ltb_idx_width_p-1:0] last_idx_lp  = '1;

    typedef enum logic {
        e_clear,
        e_run
    } state_e;

    state_e                         state;
    logic [ltb_idx_width_p-1:0]     clr_ptr;
    logic                           wb_v;
    logic [ltb_idx_width_p-1:0]     wb_idx;
    logic [ltb_entry_width_p-1:0]   wb_data;
    logic [stall_width_lp-1:0]      stall_cnt;
    logic                           pred_v_r;
    logic                           fwd_r;
    logic [ltb_entry_width_p-1:0]   fwd_data_r;

    logic [ltb_idx_width_p-1:0]     r_idx;
    logic [ltb_idx_width_p-1:0]     w_idx;
    logic                           run;
    logic                           force_w;
    logic                           read_grant;
    logic                           wb_drain;
    logic                           w_accept;
    logic                           fwd_hit;

    // Entries are word-indexed; the byte offset and upper PC bits do not select an entry.
    assign r_idx = r_addr_i[ltb_idx_width_p+1:2];
    assign w_idx = w_addr_i[ltb_idx_width_p+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{r_addr_i[vaddr_width_p-1:ltb_idx_width_p+2], r_addr_i[1:0],
                                w_addr_i[vaddr_width_p-1:ltb_idx_width_p+2], w_addr_i[1:0]};

    // A starved buffered write eventually pre-empts reads so updates cannot be held off forever.
    assign run        = (state == e_run);
    assign force_w    = wb_v && (stall_cnt == stall_max_lp);
    assign read_grant = run && r_v_i && !force_w;
    assign wb_drain   = run && wb_v && !read_grant;
    assign w_accept   = run && w_v_i && (!wb_v || wb_drain);
    assign fwd_hit    = wb_v && (wb_idx == r_idx);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path infers a latch.
        r_ready_o   = 1'b0;
        w_yumi_o    = 1'b0;
        ram_v_o     = 1'b0;
        ram_w_o     = 1'b0;
        ram_addr_o  = '0;
        ram_data_o  = '0;
        init_done_o = 1'b0;
        if (reset_n_i) begin
            unique case (state)
                e_clear: begin
                    ram_v_o    = 1'b1;
                    ram_w_o    = 1'b1;
                    ram_addr_o = clr_ptr;
                end
                e_run: begin
                    init_done_o = 1'b1;
                    r_ready_o   = !force_w;
                    w_yumi_o    = w_accept;
                    if (wb_drain) begin
                        ram_v_o    = 1'b1;
                        ram_w_o    = 1'b1;
                        ram_addr_o = wb_idx;
                        ram_data_o = wb_data;
                    end else if (read_grant) begin
                        ram_v_o    = 1'b1;
                        ram_addr_o = r_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pred_v_o    = reset_n_i && pred_v_r;
    assign pred_data_o = !reset_n_i ? '0 : (fwd_r ? fwd_data_r : ram_data_i);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state     <= e_clear;
            clr_ptr   <= '0;
            wb_v      <= 1'b0;
            stall_cnt <= '0;
            pred_v_r  <= 1'b0;
            fwd_r     <= 1'b0;
        end else begin
            unique case (state)
                e_clear: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == last_idx_lp) begin
                        state <= e_run;
                    end
                end
                e_run:   ;
                default: state <= e_clear;
            endcase

            pred_v_r <= read_grant;
            if (read_grant) begin
                fwd_r <= fwd_hit;
            end

            if (w_accept) begin
                wb_v <= 1'b1;
            end else if (wb_drain) begin
                wb_v <= 1'b0;
            end

            if (wb_drain) begin
                stall_cnt <= '0;
            end else if (wb_v && read_grant && (stall_cnt != stall_max_lp)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // NOTE: payload registers carry no reset; their matching valid bits above gate every use.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            wb_idx  <= w_idx;
            wb_data <= w_data_i;
        end
        if (read_grant) begin
            fwd_data_r <= wb_data;
        end
    end

endmodule
